// File: rtl/layer_scheduler_pkg.sv
// Shared types and constants for the point-wise layer scheduler.
package layer_scheduler_pkg;

  localparam int LANES  = 16;
  localparam int BEAT_W = $clog2(LANES);

  localparam logic RD_SEL_WEIGHT = 1'b1;
  localparam logic RD_SEL_INPUT  = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    LD_W,
    LD_I,
    DRAIN,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/layer_scheduler_if.sv
// Global-buffer read / write-back beat bus driven by the layer scheduler.
interface layer_scheduler_if
  import layer_scheduler_pkg::*;
#(
  parameter int GB_ADDR_W = 16
);
  logic                 gb_ren;
  logic [GB_ADDR_W-1:0] gb_raddr;
  logic                 rd_sel;
  logic [BEAT_W-1:0]    rd_idx;
  logic                 acc_clear;
  logic                 out_wen;
  logic [GB_ADDR_W-1:0] out_waddr;
  logic [BEAT_W-1:0]    wb_row;

  modport master (
    output gb_ren, gb_raddr, rd_sel, rd_idx, acc_clear, out_wen, out_waddr, wb_row
  );

  modport slave (
    input gb_ren, gb_raddr, rd_sel, rd_idx, acc_clear, out_wen, out_waddr, wb_row
  );
endinterface

// File: rtl/layer_addr_gen.sv
// Tile / output-chunk / input-chunk / beat counters and the three GB address generators.
module layer_addr_gen
  import layer_scheduler_pkg::*;
#(
  parameter int GB_ADDR_W = 16,
  parameter int LEN_W     = 13,
  localparam int CNT_W    = LEN_W - BEAT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_ld,
  input  logic [CNT_W-1:0]     ich_in,
  input  logic [CNT_W-1:0]     och_in,
  input  logic [CNT_W-1:0]     tiles_in,
  input  logic [GB_ADDR_W-1:0] init_input_addr,
  input  logic [GB_ADDR_W-1:0] init_weight_addr,
  input  logic [GB_ADDR_W-1:0] init_output_addr,
  input  logic                 k_inc,
  input  logic                 ic_inc,
  input  logic                 blk_inc,
  output logic [BEAT_W-1:0]    k,
  output logic                 ic_first,
  output logic                 ic_last,
  output logic                 blk_last,
  output logic [GB_ADDR_W-1:0] w_addr,
  output logic [GB_ADDR_W-1:0] i_addr,
  output logic [GB_ADDR_W-1:0] o_addr
);
  localparam int AW = GB_ADDR_W + LEN_W;

  logic [CNT_W-1:0]     ich, och, tiles;
  logic [CNT_W-1:0]     t, oc, ic;
  logic [GB_ADDR_W-1:0] base_i, base_w, base_o;

  // Layer geometry and region bases are data: captured on an accepted start, never reset.
  always_ff @(posedge clk) begin
    if (cfg_ld) begin
      ich    <= ich_in;
      och    <= och_in;
      tiles  <= tiles_in;
      base_i <= init_input_addr;
      base_w <= init_weight_addr;
      base_o <= init_output_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cfg_ld) begin
      k  <= '0;
      ic <= '0;
      oc <= '0;
      t  <= '0;
    end else begin
      if (k_inc)  k  <= k + BEAT_W'(1);
      if (ic_inc) ic <= ic + CNT_W'(1);
      if (blk_inc) begin
        ic <= '0;
        if (oc == och - CNT_W'(1)) begin
          oc <= '0;
          t  <= t + CNT_W'(1);
        end else begin
          oc <= oc + CNT_W'(1);
        end
      end
    end
  end

  assign ic_first = (ic == '0);
  assign ic_last  = (ic == ich - CNT_W'(1));
  assign blk_last = (t == tiles - CNT_W'(1)) && (oc == och - CNT_W'(1));

  // Wide intermediates, then silent modulo-2^GB_ADDR_W wrap.
  assign w_addr = GB_ADDR_W'(AW'(base_w) + ((AW'(oc) * AW'(ich) + AW'(ic)) << BEAT_W) + AW'(k));
  assign i_addr = GB_ADDR_W'(AW'(base_i) + ((AW'(t) << BEAT_W) + AW'(k)) * AW'(ich) + AW'(ic));
  assign o_addr = GB_ADDR_W'(AW'(base_o) + ((AW'(t) << BEAT_W) + AW'(k)) * AW'(och) + AW'(oc));

endmodule

// File: rtl/layer_scheduler.sv
// Point-wise layer sequencer: walks tile/oc/ic, issues weight and input read bursts, then write-back.
module layer_scheduler
  import layer_scheduler_pkg::*;
#(
  parameter int GB_ADDR_W = 16,
  parameter int LEN_W     = 13,
  parameter int DRAIN_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_done,
  input  logic                 stall,
  input  logic [LEN_W-1:0]     n_sample,
  input  logic [LEN_W-1:0]     in_feat_len,
  input  logic [LEN_W-1:0]     out_feat_len,
  input  logic [GB_ADDR_W-1:0] init_input_addr,
  input  logic [GB_ADDR_W-1:0] init_weight_addr,
  input  logic [GB_ADDR_W-1:0] init_output_addr,
  layer_scheduler_if.master    gb,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);
  localparam int DCNT_W = $clog2(DRAIN_LAT + 1);

  state_t                 state, state_nx;
  logic [DCNT_W-1:0]      dcnt;
  logic                   cfg_ok, cfg_ld, cfg_err_nx;
  logic                   k_inc, ic_inc, blk_inc;
  logic [BEAT_W-1:0]      k;
  logic                   beat_end, ic_first, ic_last, blk_last;
  logic [GB_ADDR_W-1:0]   w_addr, i_addr, o_addr;

  function automatic logic len_ok(input logic [LEN_W-1:0] len);
    return (len != '0) && (len[BEAT_W-1:0] == '0);
  endfunction

  assign cfg_ok   = len_ok(n_sample) && len_ok(in_feat_len) && len_ok(out_feat_len);
  assign beat_end = (k == BEAT_W'(LANES - 1));

  layer_addr_gen #(
    .GB_ADDR_W(GB_ADDR_W),
    .LEN_W    (LEN_W)
  ) u_addr_gen (
    .clk             (clk),
    .rst             (rst),
    .cfg_ld          (cfg_ld),
    .ich_in          (in_feat_len[LEN_W-1:BEAT_W]),
    .och_in          (out_feat_len[LEN_W-1:BEAT_W]),
    .tiles_in        (n_sample[LEN_W-1:BEAT_W]),
    .init_input_addr (init_input_addr),
    .init_weight_addr(init_weight_addr),
    .init_output_addr(init_output_addr),
    .k_inc           (k_inc),
    .ic_inc          (ic_inc),
    .blk_inc         (blk_inc),
    .k               (k),
    .ic_first        (ic_first),
    .ic_last         (ic_last),
    .blk_last        (blk_last),
    .w_addr          (w_addr),
    .i_addr          (i_addr),
    .o_addr          (o_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dcnt    <= '0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_nx;
      cfg_err <= cfg_err_nx;
      if (state != DRAIN) dcnt <= '0;
      else if (!stall)    dcnt <= dcnt + DCNT_W'(1);
    end
  end

  always_comb begin
    state_nx   = state;
    cfg_ld     = 1'b0;
    cfg_err_nx = 1'b0;
    k_inc      = 1'b0;
    ic_inc     = 1'b0;
    blk_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            cfg_ld   = 1'b1;
            state_nx = WAIT_LOAD;
          end else begin
            cfg_err_nx = 1'b1;
          end
        end
      end
      WAIT_LOAD: if (load_done) state_nx = LD_W;
      LD_W: begin
        if (!stall) begin
          k_inc = 1'b1;
          if (beat_end) state_nx = LD_I;
        end
      end
      LD_I: begin
        if (!stall) begin
          k_inc = 1'b1;
          if (beat_end) begin
            if (ic_last) begin
              state_nx = DRAIN;
            end else begin
              ic_inc   = 1'b1;
              state_nx = LD_W;
            end
          end
        end
      end
      DRAIN: if (!stall && dcnt == DCNT_W'(DRAIN_LAT - 1)) state_nx = WB;
      WB: begin
        if (!stall) begin
          k_inc = 1'b1;
          if (beat_end) begin
            blk_inc  = 1'b1;
            state_nx = blk_last ? DONE : LD_W;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore decode; stall only masks the strobes, the beat itself is held by the counters.
  assign gb.gb_ren    = (state == LD_W || state == LD_I) && !stall;
  assign gb.gb_raddr  = (state == LD_W) ? w_addr : (state == LD_I) ? i_addr : '0;
  assign gb.rd_sel    = (state == LD_W) ? RD_SEL_WEIGHT : RD_SEL_INPUT;
  assign gb.rd_idx    = (state == LD_W || state == LD_I) ? k : '0;
  assign gb.acc_clear = (state == LD_W) && !stall && (k == '0) && ic_first;
  assign gb.out_wen   = (state == WB) && !stall;
  assign gb.out_waddr = (state == WB) ? o_addr : '0;
  assign gb.wb_row    = (state == WB) ? k : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);

endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: nested-loop beat model compared every cycle, directed and random layers.
module tb_layer_scheduler;
  import layer_scheduler_pkg::*;

  localparam int GB_ADDR_W = 16;
  localparam int LEN_W     = 13;
  localparam int DRAIN_LAT = 4;

  logic                 clk, rst, start, load_done, stall;
  logic [LEN_W-1:0]     n_sample, in_feat_len, out_feat_len;
  logic [GB_ADDR_W-1:0] init_input_addr, init_weight_addr, init_output_addr;
  logic                 busy, done, cfg_err;

  layer_scheduler_if #(.GB_ADDR_W(GB_ADDR_W)) gb ();

  layer_scheduler #(
    .GB_ADDR_W(GB_ADDR_W),
    .LEN_W    (LEN_W),
    .DRAIN_LAT(DRAIN_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .load_done       (load_done),
    .stall           (stall),
    .n_sample        (n_sample),
    .in_feat_len     (in_feat_len),
    .out_feat_len    (out_feat_len),
    .init_input_addr (init_input_addr),
    .init_weight_addr(init_weight_addr),
    .init_output_addr(init_output_addr),
    .gb              (gb),
    .busy            (busy),
    .done            (done),
    .cfg_err         (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        first;
    logic        ren;
    logic        sel;
    logic [3:0]  idx;
    logic [15:0] raddr;
    logic        clr;
    logic        wen;
    logic [15:0] waddr;
    logic [3:0]  row;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t        expq[$];
  logic        mon_on;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          first_cyc = 0;
  int          done_cyc = 0;
  int          stall_cnt = 0;
  int          clr_cnt = 0;
  int          wen_cnt = 0;
  logic [15:0] wlog[$];
  logic [15:0] ilog[$];
  logic [15:0] olog[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
    end
  endtask

  function automatic exp_t busy_entry();
    exp_t e;
    e      = '0;
    e.busy = 1'b1;
    return e;
  endfunction

  // Expected beat stream of one layer, straight from the loop nest t / oc / ic / k.
  task automatic build(input int n, input int il, input int ol,
                       input logic [15:0] bi, input logic [15:0] bw, input logic [15:0] bo);
    int   tiles, ich, och;
    exp_t e;
    tiles = n / 16;
    ich   = il / 16;
    och   = ol / 16;
    expq.delete();
    for (int t = 0; t < tiles; t++) begin
      for (int oc = 0; oc < och; oc++) begin
        for (int ic = 0; ic < ich; ic++) begin
          for (int k = 0; k < 16; k++) begin
            e       = busy_entry();
            e.first = (t == 0 && oc == 0 && ic == 0 && k == 0);
            e.ren   = 1'b1;
            e.sel   = 1'b1;
            e.idx   = 4'(k);
            e.raddr = 16'(int'(bw) + (oc * ich + ic) * 16 + k);
            e.clr   = (ic == 0 && k == 0);
            expq.push_back(e);
          end
          for (int k = 0; k < 16; k++) begin
            e       = busy_entry();
            e.ren   = 1'b1;
            e.idx   = 4'(k);
            e.raddr = 16'(int'(bi) + (t * 16 + k) * ich + ic);
            expq.push_back(e);
          end
        end
        for (int d = 0; d < DRAIN_LAT; d++) expq.push_back(busy_entry());
        for (int k = 0; k < 16; k++) begin
          e       = busy_entry();
          e.wen   = 1'b1;
          e.waddr = 16'(int'(bo) + (t * 16 + k) * och + oc);
          e.row   = 4'(k);
          expq.push_back(e);
        end
      end
    end
    e      = busy_entry();
    e.done = 1'b1;
    expq.push_back(e);
    e = '0;
    expq.push_back(e);
  endtask

  // Single compare process: one model entry per non-stalled cycle.
  initial begin : compare
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (mon_on && expq.size() > 0) begin
        e = expq[0];
        checks++;
        if (stall && e.busy && !e.done) begin
          stall_cnt++;
          bad = (gb.gb_ren !== 1'b0) || (gb.out_wen !== 1'b0) || (gb.acc_clear !== 1'b0) ||
                (busy !== 1'b1) || (done !== 1'b0) || (cfg_err !== 1'b0);
          if (bad) begin
            errors++;
            $display("FAIL stall_hold cyc %0d: got ren=%b wen=%b clr=%b busy=%b done=%b, required ren=0 wen=0 clr=0 busy=1 done=0",
                     cyc, gb.gb_ren, gb.out_wen, gb.acc_clear, busy, done);
          end
        end else begin
          bad = (gb.gb_ren !== e.ren) || (gb.out_wen !== e.wen) || (gb.acc_clear !== e.clr) ||
                (busy !== e.busy) || (done !== e.done) || (cfg_err !== 1'b0);
          if (e.ren) bad = bad || (gb.rd_sel !== e.sel) || (gb.rd_idx !== e.idx) || (gb.gb_raddr !== e.raddr);
          if (e.wen) bad = bad || (gb.out_waddr !== e.waddr) || (gb.wb_row !== e.row);
          if (bad) begin
            errors++;
            $display("FAIL beat cyc %0d: got ren=%b sel=%b idx=%0d raddr=%h clr=%b wen=%b waddr=%h row=%0d busy=%b done=%b; required ren=%b sel=%b idx=%0d raddr=%h clr=%b wen=%b waddr=%h row=%0d busy=%b done=%b",
                     cyc, gb.gb_ren, gb.rd_sel, gb.rd_idx, gb.gb_raddr, gb.acc_clear, gb.out_wen,
                     gb.out_waddr, gb.wb_row, busy, done, e.ren, e.sel, e.idx, e.raddr, e.clr,
                     e.wen, e.waddr, e.row, e.busy, e.done);
          end
          if (e.first) begin
            first_cyc = cyc;
            stall_cnt = 0;
            clr_cnt   = 0;
            wen_cnt   = 0;
            wlog.delete();
            ilog.delete();
            olog.delete();
          end
          if (gb.gb_ren === 1'b1) begin
            if (gb.rd_sel) wlog.push_back(gb.gb_raddr);
            else           ilog.push_back(gb.gb_raddr);
          end
          if (gb.out_wen === 1'b1) begin
            olog.push_back(gb.out_waddr);
            wen_cnt++;
          end
          if (gb.acc_clear === 1'b1) clr_cnt++;
          if (e.done) done_cyc = cyc;
          void'(expq.pop_front());
        end
      end
      cyc++;
    end
  end

  // smode: 0 quiet, 1 stall window [sat, sat+slen) plus one start while busy, 2 random stall/junk.
  task automatic run_layer(input int n, input int il, input int ol,
                           input logic [15:0] bi, input logic [15:0] bw, input logic [15:0] bo,
                           input int smode, input int sat, input int slen, output int span);
    int cyc_i, budget;
    build(n, il, ol, bi, bw, bo);
    budget = expq.size() * 4 + 200;
    @(posedge clk);
    #1;
    n_sample         = 13'(n);
    in_feat_len      = 13'(il);
    out_feat_len     = 13'(ol);
    init_input_addr  = bi;
    init_weight_addr = bw;
    init_output_addr = bo;
    start            = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("start_accept_busy", 32'(busy), 1);
    if (smode == 2) repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk);
    #1 load_done = 1'b1;
    @(posedge clk);
    #1;
    load_done = 1'b0;
    mon_on    = 1'b1;
    cyc_i     = 0;
    stall     = (smode == 1 && sat == 0 && slen > 0) || (smode == 2 && $urandom_range(0, 7) == 0);
    forever begin
      @(posedge clk);
      if (expq.size() == 0) break;
      if (cyc_i > budget) begin
        checks++;
        errors++;
        $display("FAIL layer_timeout: got %0d entries left after %0d cycles, required 0", expq.size(), cyc_i);
        break;
      end
      #1;
      cyc_i++;
      stall = (smode == 1 && cyc_i >= sat && cyc_i < sat + slen) ||
              (smode == 2 && $urandom_range(0, 7) == 0);
      start = (expq.size() > 2) &&
              ((smode == 1 && cyc_i == 10) || (smode == 2 && $urandom_range(0, 15) == 0));
      load_done = (smode == 2 && expq.size() > 2 && $urandom_range(0, 15) == 0);
      if (start) begin
        in_feat_len      = 13'(16 * $urandom_range(1, 4));
        init_input_addr  = 16'($urandom_range(0, 65535));
        init_output_addr = 16'($urandom_range(0, 65535));
      end
    end
    #1;
    mon_on    = 1'b0;
    stall     = 1'b0;
    start     = 1'b0;
    load_done = 1'b0;
    expq.delete();
    span = done_cyc - first_cyc + 1;
  endtask

  initial begin : main
    int          span, n, il, ol, tiles, ich, och, exp_span;
    logic [15:0] bi, bw, bo;
    int          bad_cfg[5][3];

    rst = 1'b1; start = 1'b0; load_done = 1'b0; stall = 1'b0; mon_on = 1'b0;
    n_sample = '0; in_feat_len = '0; out_feat_len = '0;
    init_input_addr = '0; init_weight_addr = '0; init_output_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_raddr", 32'(gb.gb_raddr), 0);
    chk("reset_waddr", 32'(gb.out_waddr), 0);
    chk("reset_ctl", 32'({gb.gb_ren, gb.rd_sel, gb.rd_idx, gb.acc_clear, gb.out_wen, gb.wb_row, busy, done, cfg_err}), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Minimal layer
    run_layer(16, 16, 16, 16'h0000, 16'h4000, 16'h8000, 0, 0, 0, span);
    chk("min_span", 32'(span), 53);
    chk("min_w_count", 32'(wlog.size()), 16);
    chk("min_w_first", 32'(wlog[0]), 'h4000);
    chk("min_w_last", 32'(wlog[15]), 'h400F);
    chk("min_i_count", 32'(ilog.size()), 16);
    chk("min_i_last", 32'(ilog[15]), 'h000F);
    chk("min_o_first", 32'(olog[0]), 'h8000);
    chk("min_o_last", 32'(olog[15]), 'h800F);

    // Multi-chunk layer
    run_layer(32, 32, 32, 16'h0000, 16'h4000, 16'h8000, 0, 0, 0, span);
    chk("multi_span", 32'(span), 337);
    chk("multi_clr_count", 32'(clr_cnt), 4);
    chk("multi_t1_ic1_first", 32'(ilog[80]), 'h0021);
    chk("multi_t1_ic1_second", 32'(ilog[81]), 'h0023);
    chk("multi_t1_ic1_last", 32'(ilog[95]), 'h003F);

    // Full layer
    run_layer(1024, 16, 64, 16'h0000, 16'h4000, 16'h8000, 0, 0, 0, span);
    chk("full_span", 32'(span), 13313);
    chk("full_wb_bursts", 32'(wen_cnt / 16), 256);
    chk("full_wb_beats", 32'(wen_cnt), 4096);

    // Stall on LD_I beat 5 for 3 cycles, plus one start while busy
    run_layer(16, 16, 16, 16'h0000, 16'h4000, 16'h8000, 1, 21, 3, span);
    chk("stall_span", 32'(span), 56);
    chk("stall_stall_cnt", 32'(stall_cnt), 3);
    chk("stall_i_count", 32'(ilog.size()), 16);
    chk("stall_i_beat5", 32'(ilog[5]), 'h0005);
    chk("stall_i_beat6", 32'(ilog[6]), 'h0006);

    // Rejected configurations
    bad_cfg = '{'{16, 24, 16}, '{0, 16, 16}, '{16, 16, 40}, '{20, 16, 16}, '{16, 16, 0}};
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_sample     = 13'(bad_cfg[i][0]);
      in_feat_len  = 13'(bad_cfg[i][1]);
      out_feat_len = 13'(bad_cfg[i][2]);
      start        = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      chk($sformatf("cfg_err_pulse_%0d", i), 32'({cfg_err, busy}), 'b10);
      @(negedge clk);
      chk($sformatf("cfg_err_clear_%0d", i), 32'({cfg_err, busy}), 'b00);
    end

    // Reset in the middle of write-back
    @(posedge clk);
    #1;
    n_sample = 13'd16; in_feat_len = 13'd16; out_feat_len = 13'd16;
    init_input_addr = 16'h0000; init_weight_addr = 16'h4000; init_output_addr = 16'h8000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 load_done = 1'b1;
    @(posedge clk);
    #1 load_done = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_in_wb", 32'({gb.out_wen, busy}), 'b11);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_raddr", 32'(gb.gb_raddr), 0);
    chk("rst_mid_waddr", 32'(gb.out_waddr), 0);
    chk("rst_mid_ctl", 32'({gb.gb_ren, gb.rd_sel, gb.rd_idx, gb.acc_clear, gb.out_wen, gb.wb_row, busy, done, cfg_err}), 0);
    @(posedge clk);
    #1 load_done = 1'b1;
    @(posedge clk);
    #1 load_done = 1'b0;
    @(negedge clk);
    chk("idle_ignores_load_done", 32'({gb.gb_ren, busy}), 0);
    run_layer(16, 16, 16, 16'h0000, 16'h4000, 16'h8000, 0, 0, 0, span);
    chk("post_reset_span", 32'(span), 53);

    // Output address wrap
    run_layer(16, 16, 16, 16'h0000, 16'h4000, 16'hFFF8, 0, 0, 0, span);
    chk("wrap_o_top", 32'(olog[7]), 'hFFFF);
    chk("wrap_o_zero", 32'(olog[8]), 'h0000);
    chk("wrap_o_last", 32'(olog[15]), 'h0007);

    // Random layers with random stall, junk start and load_done
    for (int r = 0; r < 6; r++) begin
      n  = 16 * $urandom_range(1, 3);
      il = 16 * $urandom_range(1, 4);
      ol = 16 * $urandom_range(1, 3);
      bi = 16'($urandom_range(0, 65535));
      bw = 16'($urandom_range(0, 65535));
      bo = 16'($urandom_range(0, 65535));
      run_layer(n, il, ol, bi, bw, bo, 2, 0, 0, span);
      tiles    = n / 16;
      ich      = il / 16;
      och      = ol / 16;
      exp_span = tiles * och * (32 * ich + DRAIN_LAT + 16) + 1 + stall_cnt;
      chk($sformatf("rand_span_%0d", r), 32'(span), 32'(exp_span));
      chk($sformatf("rand_wb_beats_%0d", r), 32'(wen_cnt), 32'(tiles * och * 16));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_scheduler.md
# layer_scheduler

Sequences one point-wise layer over the global buffer and PE array once the external load of inputs, weights and NIT is complete. It walks point tiles, output-channel chunks and input-channel chunks, and issues global-buffer read beats (weights, then inputs) to the PE array. After each block it issues output write-back beats with the matching addresses. It sits between the top-level start/LOAD_DONE/config registers and the GB read/write address ports.

## Interface
- GB_ADDR_W, 16, global buffer address width
- LEN_W, 13, width of N_SAMPLE / feature-length fields
- LANES, 16, bytes per GB line = PE rows = PE columns
- DRAIN_LAT, 4, cycles between last input beat and first write-back beat (PE pipeline depth)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; latches config
- load_done  in  1  one-cycle pulse; external GB/NIT load finished
- stall  in  1  freeze all counters and suppress beats
- n_sample  in  LEN_W  points in layer
- in_feat_len, out_feat_len  in  LEN_W  feature lengths
- init_input_addr, init_weight_addr, init_output_addr  in  GB_ADDR_W  region bases
- gb_ren  out  1  GB read beat
- gb_raddr  out  GB_ADDR_W  read address
- rd_sel  out  1  1 = weight beat, 0 = input beat
- rd_idx  out  4  beat index within the 16-beat burst
- acc_clear  out  1  PE accumulators clear; coincides with the first beat of ic=0
- out_wen  out  1  write-back beat
- out_waddr  out  GB_ADDR_W  write-back address
- wb_row  out  4  PE row being written back
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle completion pulse
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- Derived counts, latched at start:
  - ICH = in_feat_len/16
  - OCH = out_feat_len/16
  - TILES = n_sample/16
- Config is rejected when any of the three lengths is 0 or not a multiple of 16. On rejection: cfg_err pulses and the block stays in IDLE.
- States and transitions:
  - IDLE → WAIT_LOAD on valid start.
  - WAIT_LOAD → LD_W on load_done.
  - LD_W (16 beats) → LD_I (16 beats).
  - LD_I → LD_W if ic < ICH-1, else DRAIN.
  - DRAIN (DRAIN_LAT cycles) → WB (16 beats).
  - WB → LD_W for the next oc or tile, else DONE.
  - DONE → IDLE.
- Loop order, outer to inner: tile t, oc, ic; beat k = 0..15.
- Addresses, modulo 2^GB_ADDR_W (wrap-around is silent):
  - weight: init_weight_addr + (oc·ICH + ic)·16 + k
  - input: init_input_addr + (t·16 + k)·ICH + ic
  - output: init_output_addr + (t·16 + k)·OCH + oc; wb_row = k
- Outputs are Moore-decoded from state and counters.
- stall high: gb_ren = out_wen = 0, all counters and state hold, and the beat resumes unchanged when stall drops. stall is ignored in IDLE, WAIT_LOAD and DONE.
- start while busy: ignored. load_done outside WAIT_LOAD: ignored.
- Counter widths: intermediates use GB_ADDR_W+LEN_W bits, then truncate to GB_ADDR_W.

## Timing
- rst high: state = IDLE, all counters 0, all outputs 0 at the next edge. This holds mid-operation too; there is no partial write-back.
- load_done high at edge E: first weight beat (gb_ren = 1, rd_sel = 1, acc_clear = 1) occurs in the cycle after E.
- Per (t, oc) block with no stall: 32·ICH + DRAIN_LAT + 16 cycles.
- done rises one cycle after the last WB beat. busy falls one cycle later.
- Total cycles from the first beat to done: TILES·OCH·(32·ICH + DRAIN_LAT + 16) + 1.
- Every stall cycle adds exactly one cycle.

## Structure
- Shared package: the state enum (IDLE, WAIT_LOAD, LD_W, LD_I, DRAIN, WB, DONE), the LANES=16 and beat-index width constants, and the rd_sel encodings.
- One sub-module, layer_addr_gen: holds the t/oc/ic/k counters and the three address computations. The FSM stays in layer_scheduler.

## Test plan
- Minimal layer: N=16, in=16, out=16, DRAIN_LAT=4, bases 0x0000/0x4000/0x8000. Required response:
  - weight beats 0x4000..0x400F
  - input beats 0x0000..0x000F
  - after 4 idle cycles, writes 0x8000..0x800F
  - done 53 cycles after the first beat
- Multi-chunk: N=32, in=32, out=32. Required response:
  - input addresses for t=1, ic=1 run 0x0021, 0x0023, …, 0x003F
  - acc_clear occurs only on ic=0 beats; 4 blocks in total
- Full layer: N=1024, in=16, out=64. Required response: exactly 256 WB bursts; done 13313 cycles after the first beat.
- Stall: assert stall for 3 cycles on LD_I beat 5. Required response: no gb_ren during the stall, beat 5 address repeats when stall drops, done is delayed by 3 cycles.
- Config errors: in_feat_len = 24 → cfg_err pulse, busy stays 0. start while busy → ignored, addresses unaffected.
- Reset and wrap: assert rst mid-WB → all outputs 0 at the next edge, state IDLE. Set init_output_addr = 0xFFF8 → write addresses wrap to 0x0000..0x0007.
